k12a_spi_target: RTL and testbench

- SPI target (slave) that sits at the far end of the k12a SPI master pins (spi_sck, spi_mosi, spi_miso).
- Used as an on-board peripheral bridge and as the self-test loopback partner for the CPU SPI port.
- Oversamples the SPI pins in the cpu_clock domain, deserialises MOSI into bytes and serialises a queued reply byte onto MISO.
- Framing is by an active-low select driven from a k12a GPIO output bit.

---
 rtl/k12a_spi_target.sv | 179 +++++++++++++++++
 tb/tb_k12a_spi_target.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_spi_target.sv
// ---------------------------------------------------------------------------
// k12a_spi_target
//
// SPI target (mode 0, MSB first, 8-bit) that oversamples the master pins in
// the cpu_clock domain. MOSI is deserialised into rx_data and a single-entry
// reply buffer feeds the MISO shifter.
//
// Ports:
//   cpu_clock, reset      : system clock, synchronous active-high reset
//   spi_sck/mosi/cs_n     : asynchronous master pins (cs_n active low)
//   spi_miso              : serial reply to master (0 while idle)
//   tx_data/valid/ready   : reply byte write port
//   rx_data/valid/ack     : received byte, level valid, consumer acknowledge
//   rx_overrun            : sticky, byte arrived while rx_valid was still set
//   tx_underrun           : sticky, DEFAULT_TX sent from an empty buffer
//   status_clear          : clears both sticky flags (a coincident set wins)
//   busy                  : frame active; this is the FSM state (1 = ACTIVE)
//
// Handshake: a reply byte transfers on any rising cpu_clock edge where
// tx_valid && tx_ready; tx_valid may wait for tx_ready but tx_ready never
// waits for tx_valid. rx_valid stays high until a cycle with rx_ack.
// ---------------------------------------------------------------------------
module k12a_spi_target #(
    parameter logic [7:0] DEFAULT_TX  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       status_clear,
    output logic       busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_next;

    // Synchronisers plus one history flop per pin; idle levels on reset so
    // leaving reset never looks like an edge.
    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_hist, cs_hist;

    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_count;
    logic [7:0] buf_data;
    logic       buf_full;

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic start_frame, in_frame, do_rise, do_fall;
    logic load_tx, byte_done, tx_write;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign cs_fall  = ~cs_s & cs_hist;
    assign cs_rise  = cs_s & ~cs_hist;

    // Deselect takes priority over any sck edge seen in the same cycle.
    assign start_frame = (state == IDLE) && cs_fall;
    assign in_frame    = (state == ACTIVE) && !cs_rise;
    assign do_rise     = in_frame && sck_rise;
    assign do_fall     = in_frame && sck_fall;

    // A reply byte is loaded at frame start and at every byte boundary.
    assign load_tx   = start_frame || (do_fall && (bit_count == 3'd0));
    assign byte_done = do_rise && (bit_count == 3'd7);
    assign tx_write  = tx_valid && !buf_full;

    assign tx_ready = ~buf_full;
    assign busy     = (state == ACTIVE);
    assign spi_miso = (state == ACTIVE) && tx_shift[7];

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            sck_sync    <= '0;
            mosi_sync   <= '0;
            cs_sync     <= '1;
            sck_hist    <= 1'b0;
            cs_hist     <= 1'b1;
            tx_shift    <= 8'h00;
            rx_shift    <= 8'h00;
            bit_count   <= 3'd0;
            buf_data    <= 8'h00;
            buf_full    <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_hist  <= sck_s;
            cs_hist   <= cs_s;

            // MISO shifter
            if (load_tx) begin
                tx_shift <= buf_full ? buf_data : DEFAULT_TX;
            end else if (do_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            // Reply buffer: a write can only land while empty, so a pop in
            // the same cycle already took DEFAULT_TX and the write is kept.
            if (tx_write) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end else if (load_tx) begin
                buf_full <= 1'b0;
            end

            // Receive side
            if (start_frame) begin
                bit_count <= 3'd0;
                rx_shift  <= 8'h00;
            end else if (do_rise) begin
                bit_count <= bit_count + 3'd1;
                rx_shift  <= {rx_shift[6:0], mosi_s};
            end

            if (byte_done) begin
                rx_data  <= {rx_shift[6:0], mosi_s};
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            // Sticky flags: a setting event beats status_clear.
            if (byte_done && rx_valid && !rx_ack) begin
                rx_overrun <= 1'b1;
            end else if (status_clear) begin
                rx_overrun <= 1'b0;
            end

            if (load_tx && !buf_full) begin
                tx_underrun <= 1'b1;
            end else if (status_clear) begin
                tx_underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_k12a_spi_target.sv
// ---------------------------------------------------------------------------
// tb_k12a_spi_target
//
// Directed bench acting as a mode-0 SPI master. Expected MISO and MOSI bytes
// are queued when stimulus is set up and popped when a byte completes.
// ---------------------------------------------------------------------------
module tb_k12a_spi_target;

    localparam int H = 6; // sck half period in cpu_clock cycles

    logic       cpu_clock = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       status_clear = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];

    k12a_spi_target dut (
        .cpu_clock    (cpu_clock),
        .reset        (reset),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .spi_miso     (spi_miso),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_overrun   (rx_overrun),
        .tx_underrun  (tx_underrun),
        .status_clear (status_clear),
        .busy         (busy)
    );

    // Clock and watchdog
    always #5 cpu_clock = ~cpu_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge cpu_clock);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge cpu_clock);
            n++;
        end
        check("tx_push_accepted", {7'd0, (n < 50)}, 8'd1);
        @(negedge cpu_clock);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        wait_cycles(H);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
    endtask

    task automatic pulse_clear();
        status_clear = 1'b1;
        wait_cycles(1);
        status_clear = 1'b0;
    endtask

    // Send nbits of m MSB first and collect MISO at each rising sck.
    // last: deselect while sck is high so the final falling edge is ignored.
    // pulse: 1 = rx_ack, 2 = status_clear, driven in the cycle the final
    // rising edge is registered.
    task automatic xfer(input logic [7:0] m, input int nbits, input bit last,
                        input bit mid_push, input logic [7:0] mid_data,
                        input int pulse, output logic [7:0] s);
        logic [7:0] exp_b;
        s = 8'h00;
        if (nbits == 8) rx_q.push_back(m);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = m[7-i];
            if (mid_push && i == 3) push_tx(mid_data);
            wait_cycles(H);
            s = {s[6:0], spi_miso};
            spi_sck = 1'b1;
            if (pulse != 0 && i == nbits - 1) begin
                wait_cycles(2);
                if (pulse == 1) rx_ack = 1'b1;
                else status_clear = 1'b1;
                wait_cycles(1);
                rx_ack = 1'b0;
                status_clear = 1'b0;
                wait_cycles(H - 3);
            end else begin
                wait_cycles(H);
            end
            if (last && i == nbits - 1) begin
                spi_cs_n = 1'b1;
                wait_cycles(H);
            end
            spi_sck = 1'b0;
        end
        if (last) wait_cycles(H);
        if (nbits == 8) begin
            exp_b = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hxx;
            check("miso_byte", s, exp_b);
            exp_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            check("rx_data", rx_data, exp_b);
            check("rx_valid_after_byte", {7'd0, rx_valid}, 8'd1);
        end
    endtask

    initial begin
        logic [7:0] s;

        // Power-on reset
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        check("por_miso", {7'd0, spi_miso}, 8'd0);
        check("por_tx_ready", {7'd0, tx_ready}, 8'd1);
        check("por_rx_data", rx_data, 8'h00);
        check("por_rx_valid", {7'd0, rx_valid}, 8'd0);
        check("por_flags", {6'd0, rx_overrun, tx_underrun}, 8'd0);
        check("por_busy", {7'd0, busy}, 8'd0);

        // Reset mid-frame drops the frame, the queued byte and the flags
        cs_start();
        check("mf_busy", {7'd0, busy}, 8'd1);
        check("mf_underrun", {7'd0, tx_underrun}, 8'd1);
        push_tx(8'h5A);
        check("mf_tx_ready_full", {7'd0, tx_ready}, 8'd0);
        reset = 1'b1;
        spi_cs_n = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);
        check("rst_miso", {7'd0, spi_miso}, 8'd0);
        check("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_flags", {6'd0, rx_overrun, tx_underrun}, 8'd0);

        // Single byte
        push_tx(8'hA5);
        miso_q.push_back(8'hA5);
        cs_start();
        check("sb_busy", {7'd0, busy}, 8'd1);
        check("sb_tx_ready_popped", {7'd0, tx_ready}, 8'd1);
        xfer(8'h3C, 8, 1'b1, 1'b0, 8'h00, 0, s);
        check("sb_underrun", {7'd0, tx_underrun}, 8'd0);
        check("sb_busy_end", {7'd0, busy}, 8'd0);
        pulse_ack();
        check("sb_ack_clears", {7'd0, rx_valid}, 8'd0);

        // Underrun over two bytes, no ack in between
        miso_q.push_back(8'hFF);
        miso_q.push_back(8'hFF);
        cs_start();
        xfer(8'h01, 8, 1'b0, 1'b0, 8'h00, 0, s);
        xfer(8'h02, 8, 1'b1, 1'b0, 8'h00, 0, s);
        check("ur_underrun", {7'd0, tx_underrun}, 8'd1);
        check("ur_overrun", {7'd0, rx_overrun}, 8'd1);
        pulse_clear();
        check("ur_cleared", {6'd0, rx_overrun, tx_underrun}, 8'd0);
        pulse_ack();

        // Back-to-back with a reply written during bit 3, each byte acked
        push_tx(8'h11);
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h22);
        cs_start();
        xfer(8'hA1, 8, 1'b0, 1'b1, 8'h22, 0, s);
        pulse_ack();
        check("bb_ack", {7'd0, rx_valid}, 8'd0);
        xfer(8'hB2, 8, 1'b1, 1'b0, 8'h00, 0, s);
        check("bb_overrun", {7'd0, rx_overrun}, 8'd0);
        check("bb_underrun", {7'd0, tx_underrun}, 8'd0);
        pulse_ack();

        // Abort after 5 bits, then a clean frame
        push_tx(8'hC3);
        cs_start();
        xfer(8'hF0, 5, 1'b0, 1'b0, 8'h00, 0, s);
        check("ab_partial_miso", s, 8'h18);
        spi_cs_n = 1'b1;
        wait_cycles(3);
        check("ab_busy", {7'd0, busy}, 8'd0);
        check("ab_rx_valid", {7'd0, rx_valid}, 8'd0);
        check("ab_miso_idle", {7'd0, spi_miso}, 8'd0);
        wait_cycles(H);
        push_tx(8'h7E);
        miso_q.push_back(8'h7E);
        cs_start();
        xfer(8'h81, 8, 1'b1, 1'b0, 8'h00, 0, s);

        // rx_ack and status_clear coincident with byte registration
        push_tx(8'h99);
        miso_q.push_back(8'h99);
        miso_q.push_back(8'hFF);
        cs_start();
        xfer(8'h5C, 8, 1'b0, 1'b0, 8'h00, 1, s);
        check("co_ack_no_overrun", {7'd0, rx_overrun}, 8'd0);
        xfer(8'h6D, 8, 1'b1, 1'b0, 8'h00, 2, s);
        check("co_set_beats_clear", {7'd0, rx_overrun}, 8'd1);
        check("co_underrun_cleared", {7'd0, tx_underrun}, 8'd0);
        pulse_clear();
        check("co_plain_clear", {7'd0, rx_overrun}, 8'd0);
        pulse_ack();
        check("co_final_ack", {7'd0, rx_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
